// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Brief    : Shared defaults for the FIFO controller slice.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_ADDR_WIDTH = 8;
    localparam int c_AF_MARGIN      = 4;

    // Default almost-full threshold sits a fixed margin below the full depth.
    function automatic int af_default(input int addr_width);
        return (1 << addr_width) - c_AF_MARGIN;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctrl_if
//  Brief    : Producer/consumer handshake and status bundle of the FIFO.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
);

    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ready;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;

    // The user side of the FIFO.
    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, full, empty, almost_full, count
    );

    // The FIFO controller side.
    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, full, empty, almost_full, count
    );

endinterface : fifo_ctrl_if
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctrl
//  Brief    : First-word-fall-through FIFO controller driving an external
//             RAM with a synchronous write port and an asynchronous read port.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = af_default(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    fifo_ctrl_if.slave            bus,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int                  c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_FULL_CNT = c_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AF_CNT   = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_ZERO     = '0;

    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_af;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_wr_do;
    logic                w_rd_do;
    logic [ADDR_WIDTH:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH:0] w_rd_ptr_nxt;
    logic [ADDR_WIDTH:0] w_count_nxt;
    logic                w_full_nxt;
    logic                w_empty_nxt;
    logic                w_af_nxt;

    // Handshake acceptance; clear discards both sides of the transfer.
    always_comb begin
        w_wr_acc = bus.wr_valid & ~r_full;
        w_rd_acc = bus.rd_ready & ~r_empty;
        w_wr_do  = w_wr_acc & ~clear;
        w_rd_do  = w_rd_acc & ~clear;
    end

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (clear) begin
            w_wr_ptr_nxt = c_ZERO;
            w_rd_ptr_nxt = c_ZERO;
            w_count_nxt  = c_ZERO;
        end else begin
            if (w_wr_do) begin
                w_wr_ptr_nxt = r_wr_ptr + c_ONE;
            end
            if (w_rd_do) begin
                w_rd_ptr_nxt = r_rd_ptr + c_ONE;
            end
            case ({w_wr_do, w_rd_do})
                2'b10:   w_count_nxt = r_count + c_ONE;
                2'b01:   w_count_nxt = r_count - c_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
        w_empty_nxt = (w_count_nxt == c_ZERO);
        w_full_nxt  = (w_count_nxt == c_FULL_CNT);
        w_af_nxt    = (w_count_nxt >= c_AF_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_empty  <= w_empty_nxt;
            r_full   <= w_full_nxt;
            r_af     <= w_af_nxt;
        end
    end

    // The write strobe is also blocked while reset is held so the RAM is
    // never disturbed by a producer that keeps wr_valid high through reset.
    assign ram_we          = w_wr_do & rst_n;
    assign ram_wr_addr     = r_wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data     = bus.wr_data;
    assign ram_rd_addr     = r_rd_ptr[ADDR_WIDTH-1:0];

    assign bus.rd_data     = ram_rd_data;
    assign bus.wr_ready    = ~r_full;
    assign bus.rd_valid    = ~r_empty;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.almost_full = r_af;
    assign bus.count       = r_count;

endmodule : fifo_ctrl
`default_nettype wire
